// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register pending-write scoreboard gating ID-to-EXE issue
module id_scoreboard #(
    parameter int AW    = 5,
    parameter int CNT_W = 2,
    parameter int NRET  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    input  logic                 rs_used,
    input  logic                 rt_used,
    input  logic [AW-1:0]        wdest,
    input  logic                 exe_allowin,
    input  logic                 flush,
    input  logic [NRET-1:0]      ret_valid,
    input  logic [NRET*AW-1:0]   ret_dest,
    output logic                 issue,
    output logic                 stall,
    output logic [(2**AW)-1:0]   busy_vec,
    output logic                 sb_err
);

    localparam int NREG = 2 ** AW;
    localparam int DW   = $clog2(NRET + 1);
    localparam int SW   = ((CNT_W > DW) ? CNT_W : DW) + 1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  under;
    logic             rs_haz;
    logic             rt_haz;
    logic             sat;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign busy_vec = busy;

    always_comb begin
        rs_haz = rs_used && (rs != '0) && busy[rs];
        rt_haz = rt_used && (rt != '0) && busy[rt];
        sat    = (wdest != '0) && (cnt[wdest] == CMAX);
        issue  = id_valid && !reset && !flush && exe_allowin && !rs_haz && !rt_haz && !sat;
        stall  = id_valid && !issue;
    end

    // Saturation blocks issue, so cnt + inc always fits in CNT_W bits.
    always_comb begin
        logic [DW-1:0] dec_cnt;
        logic [SW-1:0] avail;
        for (int r = 0; r < NREG; r++) begin
            dec_cnt = '0;
            for (int i = 0; i < NRET; i++) begin
                if (ret_valid[i] && (ret_dest[i*AW +: AW] == AW'(r))) begin
                    dec_cnt = dec_cnt + DW'(1);
                end
            end
            avail    = SW'(cnt[r]) + SW'(issue && (wdest == AW'(r)));
            under[r] = (r != 0) && (SW'(dec_cnt) > avail);
            if ((r == 0) || under[r]) begin
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = CNT_W'(avail - SW'(dec_cnt));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (|under) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed bench for id_scoreboard (CNT_W=2, NRET=2)
module tb_id_scoreboard;

    localparam int AW   = 5;
    localparam int NRET = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [AW-1:0]     rs, rt, wdest;
    logic              rs_used, rt_used;
    logic              exe_allowin;
    logic              flush;
    logic [NRET-1:0]   ret_valid;
    logic [NRET*AW-1:0] ret_dest;
    logic              issue, stall, sb_err;
    logic [31:0]       busy_vec;

    int errors = 0;
    int checks = 0;

    id_scoreboard #(.AW(AW), .CNT_W(2), .NRET(NRET)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs(rs), .rt(rt),
        .rs_used(rs_used), .rt_used(rt_used), .wdest(wdest),
        .exe_allowin(exe_allowin), .flush(flush), .ret_valid(ret_valid),
        .ret_dest(ret_dest), .issue(issue), .stall(stall),
        .busy_vec(busy_vec), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; rs = 0; rt = 0; rs_used = 0; rt_used = 0; wdest = 0;
        exe_allowin = 1; flush = 0; ret_valid = 0; ret_dest = 0;
    endtask

    task automatic instr(input logic [AW-1:0] d, input logic [AW-1:0] s, input logic su);
        id_valid = 1; wdest = d; rs = s; rs_used = su; rt = 0; rt_used = 0;
    endtask

    task automatic test_reset();
        idle(); reset = 1; id_valid = 1; #1;
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b expected 0", issue); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", stall); end
        step(); step(); reset = 0; idle(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sb_err); end
    endtask

    task automatic test_raw_hazard();
        instr(5, 0, 0); #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b expected 1", issue); end
        step(); instr(0, 5, 1); #1;
        checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL raw_busy5: got %h expected 00000020", busy_vec); end
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL raw_stall: got stall=%b issue=%b expected 1/0", stall, issue); end
        ret_valid = 2'b01; ret_dest = 10'd5; #1;
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b expected 0", issue); end
        step(); ret_valid = 0; #1;
        checks++; if (busy_vec !== 32'h0 || issue !== 1'b1) begin errors++; $display("FAIL raw_release: got busy=%h issue=%b expected 0/1", busy_vec, issue); end
        step(); idle();
        instr(12, 12, 1); #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL self_dep_issue: got %b expected 1", issue); end
        step(); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL self_dep_second: got stall=%b expected 1", stall); end
        id_valid = 0; ret_valid = 2'b01; ret_dest = 10'd12; step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL self_dep_clear: got %h expected 0", busy_vec); end
    endtask

    task automatic test_saturate();
        instr(7, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_issue%0d: got %b expected 1", k, issue); end
            step();
        end
        #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL sat_full: got stall=%b issue=%b expected 1/0", stall, issue); end
        ret_valid = 2'b01; ret_dest = 10'd7; step(); ret_valid = 0; #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_after_retire: got %b expected 1", issue); end
        step(); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_refull: got stall=%b expected 1", stall); end
        id_valid = 0; ret_valid = 2'b11; ret_dest = {5'd7, 5'd7}; step();
        ret_valid = 2'b01; ret_dest = 10'd7; #1;
        checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL sat_drain_mid: got %h expected 00000080", busy_vec); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL sat_drain_end: got busy=%h err=%b expected 0/0", busy_vec, sb_err); end
    endtask

    task automatic test_multi_retire();
        instr(4, 0, 0); step(); step();
        id_valid = 0; ret_valid = 2'b11; ret_dest = {5'd4, 5'd4}; step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL dual_retire: got busy=%h err=%b expected 0/0", busy_vec, sb_err); end
        instr(4, 0, 0); step();
        ret_valid = 2'b01; ret_dest = 10'd4; #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL inc_dec_issue: got %b expected 1", issue); end
        step(); id_valid = 0; ret_valid = 0; #1;
        checks++; if (busy_vec !== 32'h10) begin errors++; $display("FAIL inc_dec_hold: got %h expected 00000010", busy_vec); end
        ret_valid = 2'b01; ret_dest = 10'd4; step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL inc_dec_net: got busy=%h err=%b expected 0/0", busy_vec, sb_err); end
    endtask

    task automatic test_flush();
        instr(3, 0, 0); step(); instr(9, 0, 0); step(); id_valid = 0; #1;
        checks++; if (busy_vec !== 32'h208) begin errors++; $display("FAIL flush_pre_busy: got %h expected 00000208", busy_vec); end
        id_valid = 1; wdest = 0; rt = 9; rt_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rt_hazard: got stall=%b expected 1", stall); end
        rt_used = 0; wdest = 2; flush = 1; #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL flush_issue: got issue=%b stall=%b expected 0/1", issue, stall); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL flush_clear: got %h expected 0", busy_vec); end
    endtask

    task automatic test_sb_err();
        ret_valid = 2'b01; ret_dest = 10'd0; step(); ret_valid = 0; #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL r0_retire_err: got %b expected 0", sb_err); end
        instr(0, 0, 1); rt_used = 1; #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL r0_source: got %b expected 1", issue); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL r0_dest_busy: got %h expected 0", busy_vec); end
        ret_valid = 2'b01; ret_dest = 10'd9; step(); ret_valid = 0; step(); #1;
        checks++; if (sb_err !== 1'b1 || busy_vec !== 32'h0) begin errors++; $display("FAIL underflow: got err=%b busy=%h expected 1/0", sb_err, busy_vec); end
        instr(9, 0, 0); step(); id_valid = 0; ret_valid = 2'b01; ret_dest = 10'd9; step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b1) begin errors++; $display("FAIL underflow_cnt0: got busy=%h err=%b expected 0/1", busy_vec, sb_err); end
    endtask

    task automatic test_allowin_reset();
        instr(6, 0, 0); exe_allowin = 0; #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL allowin_stall: got stall=%b issue=%b expected 1/0", stall, issue); end
        step(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL allowin_nochange: got %h expected 0", busy_vec); end
        exe_allowin = 1; step(); instr(11, 0, 0); step(); #1;
        checks++; if (busy_vec !== 32'h840) begin errors++; $display("FAIL pre_reset_busy: got %h expected 00000840", busy_vec); end
        reset = 1; wdest = 13; #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL midreset_issue: got issue=%b stall=%b expected 0/1", issue, stall); end
        step(); reset = 0; idle(); #1;
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL midreset_clear: got busy=%h err=%b expected 0/0", busy_vec, sb_err); end
    endtask

    initial begin
        idle(); reset = 1;
        test_reset();
        test_raw_hazard();
        test_saturate();
        test_multi_retire();
        test_flush();
        test_sb_err();
        test_allowin_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
